// File: rtl/auth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : auth_pkg
// Description : Shared definitions for the rider-authentication link.
//               The command characters are common to the transmitter and to
//               the authentication receiver; the state type is shared by the
//               command arbiter and the UART serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package auth_pkg;

   localparam logic [7:0] AUTH_GO   = 8'h67;   // 'g'
   localparam logic [7:0] AUTH_STOP = 8'h73;   // 's'

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_XMIT = 1'b1
   } auth_tx_state_t;

   // Select the command character for a request; stop has priority.
   function automatic logic [7:0] auth_char(input logic is_stop,
                                            input logic [7:0] go_char,
                                            input logic [7:0] stop_char);
      return is_stop ? stop_char : go_char;
   endfunction

endpackage : auth_pkg
`default_nettype wire

// File: rtl/auth_cmd_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : auth_cmd_tx_if
// Description : Command / status bundle of the authentication transmitter.
//               master : requester side (drives send_go / send_stop)
//               slave  : transmitter side (drives TX, busy, tx_done, last_cmd)
// Ports       : send_go, send_stop  one-cycle command requests
//               TX                  serial line, idle high
//               busy                frame in flight or command pending
//               tx_done             one-cycle pulse at end of stop bit
//               last_cmd            0 = last frame GO, 1 = STOP
// Revision    : 1.0 - initial release
// ============================================================================
interface auth_cmd_tx_if;

   logic send_go;
   logic send_stop;
   logic TX;
   logic busy;
   logic tx_done;
   logic last_cmd;

   modport master (
      output send_go,
      output send_stop,
      input  TX,
      input  busy,
      input  tx_done,
      input  last_cmd
   );

   modport slave (
      input  send_go,
      input  send_stop,
      output TX,
      output busy,
      output tx_done,
      output last_cmd
   );

endinterface : auth_cmd_tx_if
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART serializer. A trmt pulse while idle loads
//               {stop, data, start} into a 10-bit shift register; each bit is
//               held for BAUD_DIV clocks, TX is the shift register LSB.
//               tx_done pulses for one cycle once the stop bit has completed.
// Ports       : clk, rst_n        clock, asynchronous active-low reset
//               trmt              start a frame (honoured only while idle)
//               tx_data[7:0]      byte to send, sampled with trmt
//               TX                serial output, idle high
//               tx_done           one-cycle end-of-frame pulse
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
   import auth_pkg::*;
#(
   parameter int BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       TX,
   output logic       tx_done
);

   localparam int                  c_baud_w   = $clog2(BAUD_DIV);
   localparam logic [c_baud_w-1:0] c_baud_max = c_baud_w'(BAUD_DIV - 1);
   localparam logic [c_baud_w-1:0] c_baud_one = c_baud_w'(1);
   localparam logic [3:0]          c_last_bit = 4'd9;

   auth_tx_state_t      r_state;
   logic [c_baud_w-1:0] r_baud_cnt;
   logic [3:0]          r_bit_cnt;
   logic [9:0]          r_shift;
   logic                r_tx_done;
   logic                w_baud_tc;

   assign w_baud_tc = (r_baud_cnt == c_baud_max);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= TX_IDLE;
         r_baud_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '1;
         r_tx_done  <= 1'b0;
      end else begin
         r_tx_done <= 1'b0;
         case (r_state)
            TX_IDLE: begin
               r_baud_cnt <= '0;
               r_bit_cnt  <= '0;
               if (trmt) begin
                  r_shift <= {1'b1, tx_data, 1'b0};
                  r_state <= TX_XMIT;
               end
            end
            TX_XMIT: begin
               if (w_baud_tc) begin
                  r_baud_cnt <= '0;
                  // Shifting in ones leaves the register all-ones after the
                  // stop bit, so TX naturally rests high when idle.
                  r_shift    <= {1'b1, r_shift[9:1]};
                  if (r_bit_cnt == c_last_bit) begin
                     r_bit_cnt <= '0;
                     r_state   <= TX_IDLE;
                     r_tx_done <= 1'b1;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + c_baud_one;
               end
            end
            default: r_state <= TX_IDLE;
         endcase
      end
   end

   assign TX      = r_shift[0];
   assign tx_done = r_tx_done;

endmodule : uart_tx
`default_nettype wire

// File: rtl/auth_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module      : auth_cmd_tx
// Description : Transmit side of the rider-authentication link. Sends the GO
//               and STOP command bytes as 8N1 frames. A one-deep pending
//               slot (last request wins, STOP beats GO in the same cycle)
//               holds a command requested mid-frame; it is launched in the
//               tx_done cycle so frames are separated by one idle clock.
// Ports       : clk, rst_n        clock, asynchronous active-low reset
//               bus (slave)       send_go, send_stop, TX, busy, tx_done,
//                                 last_cmd
// Revision    : 1.0 - initial release
// ============================================================================
module auth_cmd_tx
   import auth_pkg::*;
#(
   parameter int         BAUD_DIV  = 2604,
   parameter logic [7:0] GO_CHAR   = AUTH_GO,
   parameter logic [7:0] STOP_CHAR = AUTH_STOP
) (
   input  logic         clk,
   input  logic         rst_n,
   auth_cmd_tx_if.slave bus
);

   auth_tx_state_t r_state;
   logic           r_pend_vld;
   logic           r_pend_stop;
   logic           r_cur_stop;
   logic           r_last_cmd;

   logic           w_req;
   logic           w_req_stop;
   logic           w_idle;
   logic           w_trmt;
   logic           w_start_stop;
   logic [7:0]     w_tx_data;
   logic           w_tx;
   logic           w_tx_done;

   always_comb begin
      w_req        = bus.send_go | bus.send_stop;
      w_req_stop   = bus.send_stop;
      // The serializer is already idle during its tx_done cycle, so a new
      // frame may be launched then; this gives the single idle gap clock.
      w_idle       = (r_state == TX_IDLE) | w_tx_done;
      w_trmt       = w_idle & (r_pend_vld | w_req);
      // A pending command is older than a fresh request, so it goes first.
      w_start_stop = r_pend_vld ? r_pend_stop : w_req_stop;
      w_tx_data    = auth_char(w_start_stop, GO_CHAR, STOP_CHAR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= TX_IDLE;
         r_pend_vld  <= 1'b0;
         r_pend_stop <= 1'b0;
         r_cur_stop  <= 1'b0;
         r_last_cmd  <= 1'b0;
      end else begin
         if (w_tx_done) begin
            r_last_cmd <= r_cur_stop;
         end
         if (w_trmt) begin
            r_cur_stop <= w_start_stop;
         end

         // Pending slot: drained when launched; a request arriving in the
         // same cycle refills it. While busy, a request overwrites it.
         if (w_idle && r_pend_vld) begin
            r_pend_vld <= w_req;
            if (w_req) begin
               r_pend_stop <= w_req_stop;
            end
         end else if (!w_idle && w_req) begin
            r_pend_vld  <= 1'b1;
            r_pend_stop <= w_req_stop;
         end

         case (r_state)
            TX_IDLE: begin
               if (w_trmt) begin
                  r_state <= TX_XMIT;
               end
            end
            TX_XMIT: begin
               if (w_tx_done) begin
                  r_state <= w_trmt ? TX_XMIT : TX_IDLE;
               end
            end
            default: r_state <= TX_IDLE;
         endcase
      end
   end

   uart_tx #(
      .BAUD_DIV (BAUD_DIV)
   ) u_uart_tx (
      .clk      (clk),
      .rst_n    (rst_n),
      .trmt     (w_trmt),
      .tx_data  (w_tx_data),
      .TX       (w_tx),
      .tx_done  (w_tx_done)
   );

   assign bus.TX       = w_tx;
   assign bus.busy     = (r_state == TX_XMIT) | r_pend_vld;
   assign bus.tx_done  = w_tx_done;
   assign bus.last_cmd = r_last_cmd;

endmodule : auth_cmd_tx
`default_nettype wire

// File: tb/tb_auth_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_auth_cmd_tx
// Description : Self-checking bench for auth_cmd_tx. A cycle-level reference
//               model derives expected frames from request timing; expected
//               bytes are queued and a UART-decoding monitor pops and compares
//               every frame seen on TX.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_auth_cmd_tx;

   localparam int BD = 8;
   localparam logic [7:0] C_GO   = 8'h67;
   localparam logic [7:0] C_STOP = 8'h73;

   logic clk;
   logic rst_n;
   auth_cmd_tx_if bus();

   auth_cmd_tx #(
      .BAUD_DIV  (BD),
      .GO_CHAR   (C_GO),
      .STOP_CHAR (C_STOP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int         cyc     = 0;
   int         free_at = 0;    // first edge at which a new frame may start
   int         done_at = -1;   // edge after which tx_done is high
   int         f_start = 0;
   bit         f_valid = 0;
   logic [9:0] f_bits  = '1;
   bit         pend_v  = 0;
   bit         pend_s  = 0;
   bit         cur_s   = 0;
   bit         last_exp = 0;
   logic [7:0] exp_q[$];

   task automatic m_start(input bit s);
      logic [7:0] b;
      b       = s ? C_STOP : C_GO;
      f_start = cyc;
      f_valid = 1;
      f_bits  = {1'b1, b, 1'b0};
      done_at = cyc + 10 * BD;
      free_at = done_at + 1;
      cur_s   = s;
      exp_q.push_back(b);
   endtask

   task automatic m_reset();
      free_at = 0; done_at = -1; f_valid = 0;
      pend_v = 0; pend_s = 0; cur_s = 0; last_exp = 0;
      exp_q.delete();
   endtask

   task automatic m_step(input bit go, input bit st);
      bit req;
      cyc++;
      req = go | st;
      if (cyc == done_at + 1) last_exp = cur_s;
      if (pend_v && cyc >= free_at) begin
         m_start(pend_s);
         pend_v = req;
         pend_s = st;
      end else if (req) begin
         if (cyc >= free_at) m_start(st);
         else begin
            pend_v = 1;
            pend_s = st;   // stop wins when both are high
         end
      end
   endtask

   function automatic int tx_exp();
      if (f_valid && cyc >= f_start && cyc < f_start + 10 * BD)
         return int'(f_bits[(cyc - f_start) / BD]);
      return 1;
   endfunction

   // Model step and per-cycle status checks, 1 time unit after the edge.
   always begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
         m_reset();
         chk("reset_tx", int'(bus.TX), 1);
         chk("reset_busy", int'(bus.busy), 0);
         chk("reset_tx_done", int'(bus.tx_done), 0);
         chk("reset_last_cmd", int'(bus.last_cmd), 0);
      end else begin
         m_step(bus.send_go, bus.send_stop);
         chk("tx_line", int'(bus.TX), tx_exp());
         chk("busy", int'(bus.busy), int'(pend_v || (cyc < free_at)));
         chk("tx_done", int'(bus.tx_done), int'(cyc == done_at));
         chk("last_cmd", int'(bus.last_cmd), int'(last_exp));
      end
   end

   // ---------------- UART monitor ----------------
   bit         mon_in  = 0;
   int         mon_off = 0;
   logic [9:0] mon_bits;
   logic [7:0] mon_exp;

   always begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
         mon_in = 0;
      end else if (!mon_in) begin
         if (bus.TX == 1'b0) begin
            mon_in  = 1;
            mon_off = 0;
         end
      end else begin
         mon_off++;
         if (mon_off % BD == BD / 2) mon_bits[mon_off / BD] = bus.TX;
         if (mon_off == 9 * BD + BD / 2) begin
            mon_in = 0;
            chk("start_bit", int'(mon_bits[0]), 0);
            chk("stop_bit", int'(mon_bits[9]), 1);
            chk("frame_queued", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               mon_exp = exp_q.pop_front();
               chk("frame_byte", int'(mon_bits[8:1]), int'(mon_exp));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input bit g, input bit s);
      @(negedge clk);
      bus.send_go   = g;
      bus.send_stop = s;
      @(negedge clk);
      bus.send_go   = 1'b0;
      bus.send_stop = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      bus.send_go   = 1'b0;
      bus.send_stop = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(3);

      // single GO
      pulse(1, 0);
      idle(100);
      // GO then queued STOP
      pulse(1, 0); idle(19); pulse(0, 1);
      idle(200);
      // last wins: STOP overwritten by GO
      pulse(1, 0); idle(10); pulse(0, 1); idle(5); pulse(1, 0);
      idle(200);
      // simultaneous in idle, then simultaneous while transmitting
      pulse(1, 1);
      idle(100);
      pulse(1, 0); idle(10); pulse(1, 1);
      idle(200);

      // reset at bit 4 with a pending command
      pulse(1, 0); idle(33); pulse(0, 1); idle(2);
      rst_n = 1'b0;
      #1;
      chk("rst_async_tx", int'(bus.TX), 1);
      chk("rst_async_busy", int'(bus.busy), 0);
      idle(2);
      rst_n = 1'b1;
      idle(200);

      // loopback sequence GO, STOP, GO
      pulse(1, 0); idle(84); pulse(0, 1); idle(84); pulse(1, 0);
      idle(100);

      // random requests, including boundary-cycle and simultaneous ones
      for (int i = 0; i < 4000; i++) begin
         int r;
         @(negedge clk);
         r = $urandom_range(0, 39);
         bus.send_go   = (r == 0) || (r == 2);
         bus.send_stop = (r == 1) || (r == 2);
      end
      @(negedge clk);
      bus.send_go   = 1'b0;
      bus.send_stop = 1'b0;
      idle(250);
      chk("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_auth_cmd_tx
`default_nettype wire
